usb_tx: RTL and testbench
=========================

# usb_tx

USB full-speed packet transmitter that sits directly downstream of the data buffer. On a start request from the protocol controller it serializes SYNC, PID, the buffered payload (DATA packets only), CRC16 and EOP onto the D+/D- pair. It applies bit stuffing and NRZI encoding, and pops payload bytes from the buffer through `get_tx_data`.

## Interface
- `CLKS_PER_BIT`, 8, clock cycles per USB bit period (≥ 4).
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, synchronous and active-low: one clock, registers clear on the rising edge of `clk` while `n_rst` is 0.
- `tx_start`  in  1  one-cycle request, sampled in IDLE only.
- `tx_packet`  in  3  packet type, sampled with `tx_start`:
  - 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL.
  - 6 and 7 are invalid.
- `buff_occ`  in  7  buffer byte count (0–64), sampled with `tx_start`.
- `TX_packet_data`  in  8  head byte of the buffer, valid combinationally.
- `get_tx_data`  out  1  one-cycle pop strobe to the buffer.
- `dp_out`  out  1  D+ line.
- `dm_out`  out  1  D- line.
- `tx_transfer_active`  out  1  high while a packet is on the wire.
- `tx_error`  out  1  one-cycle pulse on an invalid request.

## Operation
- FSM states: IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
- IDLE:
  - Lines drive J (`dp_out`=1, `dm_out`=0).
  - `tx_start` with code 1–5 latches the type and `buff_occ` (as remaining count), then moves to SYNC.
  - Code 0 is ignored.
  - Code 6/7 pulses `tx_error` and stays in IDLE.
- SYNC: byte 8'h80 sent LSB first, i.e. 0000_0001.
- PID: byte {~pid, pid}, LSB first. PIDs are DATA0 4'h3, DATA1 4'hB, ACK 4'h2, NAK 4'hA, STALL 4'hE.
- Exit from PID:
  - Handshakes (ACK/NAK/STALL) go to EOP_SE0.
  - DATA with count > 0 goes to DATA.
  - DATA with count 0 goes to CRC.
- DATA:
  - Each byte is sent LSB first.
  - At each byte load: `get_tx_data`=1 for exactly one clock, `TX_packet_data` captured the same clock, count decremented.
  - Count 0 after a byte completes → CRC.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, register initialised to 16'hFFFF at PID entry.
  - Updated LSB-first on payload bits only (stuffed bits excluded).
  - CRC state sends ~crc, bit 0 first, 16 bits.
- Bit stuffing:
  - Counts consecutive logical 1s from the first SYNC bit through the last CRC bit.
  - After six 1s, one extra 0 bit period is inserted; the data bit index does not advance.
  - Counter resets on any 0, including stuffed bits.
- NRZI: logical 0 toggles the line state (J↔K), logical 1 holds it. K = (`dp_out`=0, `dm_out`=1). The first SYNC bit is referenced to J.
- EOP_SE0: `dp_out`=`dm_out`=0 for 2 bit periods, no stuffing.
- EOP_J: J for 1 bit period, then IDLE. The stuff counter and NRZI state reset.
- `tx_start` while not in IDLE is ignored (no error).
- `get_tx_data` never asserts outside DATA, and never more than the latched count.

## Timing
- Reset values:
  - State IDLE.
  - `dp_out`=1, `dm_out`=0.
  - `get_tx_data`=0, `tx_transfer_active`=0, `tx_error`=0.
  - CRC 16'hFFFF, counters 0.
- Reset mid-packet: returns to IDLE on the next edge with the line driven J. There are no further pops, and the buffer is not touched; the controller flushes it.
- `tx_start` sampled at edge T:
  - `tx_transfer_active` rises and the first SYNC bit appears at T+1.
  - `tx_error`, if any, is high during T+1 only.
- Each bit period is `CLKS_PER_BIT` clocks. Line outputs change only on bit boundaries and are registered.
- `get_tx_data` is asserted in the last clock of the preceding bit period, so each new byte starts on a bit boundary with no gap.
- `tx_transfer_active` falls on the same edge the FSM enters IDLE, after the EOP_J period.

## Test plan
- ACK:
  - Stimulus: start with code 3.
  - Required: wire carries SYNC, then PID 8'hD2, SE0×2, J.
  - Required: 19 bit periods total (152 clocks active), `get_tx_data` never asserted.
- Zero-length DATA0:
  - Stimulus: code 1, `buff_occ`=0.
  - Required: PID 8'hC3, 16 CRC bits all 0 (line toggles every period), 35 bit periods total, no pops.
- DATA1 with one byte 8'hFF:
  - Stimulus: code 2, `buff_occ`=1.
  - Required: one `get_tx_data` pulse.
  - Required: stuffed 0 at bit period 22 (SYNC bit 0 = period 0), CRC matches reference model, occupancy 1→0.
- Invalid code 6:
  - Required: `tx_error` high exactly 1 cycle, lines stay J, `tx_transfer_active` stays 0.
- Reset mid-payload:
  - Stimulus: DATA0 with 4 bytes, `n_rst` pulled low after the second pop.
  - Required: J on the next edge, total of 2 pops, all outputs at reset values.
- Busy start:
  - Stimulus: `tx_start` code 3 issued during an active DATA0 packet.
  - Required: ignored, original packet completes unchanged, no `tx_error`.

Source files
------------

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16 and EOP with bit stuffing and NRZI.
// First SYNC bit is driven one clock after tx_start; each payload byte is popped in the last clock of the preceding bit.
module usb_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buff_occ,
  input  logic [7:0] TX_packet_data,
  output logic       get_tx_data,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [15:0]   crc_q, crc_d;
  logic [2:0]    ones_q, ones_d;
  logic          line_j_q, line_j_d;
  logic [3:0]    pid_q, pid_d;
  logic [6:0]    remain_q, remain_d;
  logic          dp_d, dm_d, active_d, error_d;
  logic          boundary, stuffable, emit, ebit, crc_upd, shift_bit, load_byte, to_crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
  endfunction

  function automatic logic [3:0] pid_of(input logic [2:0] code);
    case (code)
      3'd1:    pid_of = 4'h3;
      3'd2:    pid_of = 4'hB;
      3'd3:    pid_of = 4'h2;
      3'd4:    pid_of = 4'hA;
      3'd5:    pid_of = 4'hE;
      default: pid_of = 4'h0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    crc_d       = crc_q;
    ones_d      = ones_q;
    line_j_d    = line_j_q;
    pid_d       = pid_q;
    remain_d    = remain_q;
    dp_d        = dp_out;
    dm_d        = dm_out;
    active_d    = tx_transfer_active;
    error_d     = 1'b0;
    get_tx_data = 1'b0;
    emit        = 1'b0;
    ebit        = 1'b0;
    crc_upd     = 1'b0;
    shift_bit   = 1'b0;
    load_byte   = 1'b0;
    to_crc      = 1'b0;
    boundary    = (clk_cnt_q == LAST_CLK);
    stuffable   = state_q inside {SYNC, PID, DATA, CRC};

    if (state_q == IDLE) begin
      clk_cnt_d = '0;
      if (tx_start) begin
        if (tx_packet inside {[3'd1:3'd5]}) begin
          state_d   = SYNC;
          pid_d     = pid_of(tx_packet);
          remain_d  = buff_occ;
          bit_idx_d = '0;
          shreg_d   = 8'h80;
          active_d  = 1'b1;
          emit      = 1'b1;
          ebit      = 1'b0;
        end else if (tx_packet[2:1] == 2'b11) begin
          error_d = 1'b1;
        end
      end
    end else begin
      clk_cnt_d = boundary ? '0 : clk_cnt_q + 1'b1;
      if (boundary) begin
        // Stuffed zero: the data bit index holds and the CRC is untouched.
        if (stuffable && ones_q == 3'd6) begin
          emit = 1'b1;
          ebit = 1'b0;
        end else begin
          case (state_q)
            SYNC: begin
              if (bit_idx_q != 4'd7) shift_bit = 1'b1;
              else begin
                state_d   = PID;
                bit_idx_d = '0;
                shreg_d   = {~pid_q, pid_q};
                crc_d     = 16'hFFFF;
                emit      = 1'b1;
                ebit      = pid_q[0];
              end
            end
            PID: begin
              if (bit_idx_q != 4'd7) shift_bit = 1'b1;
              else if (!pid_q[0]) begin
                state_d   = EOP_SE0;
                bit_idx_d = '0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
              end else if (remain_q != 7'd0) load_byte = 1'b1;
              else to_crc = 1'b1;
            end
            DATA: begin
              if (bit_idx_q != 4'd7) begin
                shift_bit = 1'b1;
                crc_upd   = 1'b1;
              end else if (remain_q != 7'd0) load_byte = 1'b1;
              else to_crc = 1'b1;
            end
            CRC: begin
              if (bit_idx_q != 4'd15) begin
                bit_idx_d = bit_idx_q + 4'd1;
                emit      = 1'b1;
                ebit      = ~crc_q[bit_idx_q + 4'd1];
              end else begin
                state_d   = EOP_SE0;
                bit_idx_d = '0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
              end
            end
            EOP_SE0: begin
              if (bit_idx_q == 4'd0) bit_idx_d = 4'd1;
              else begin
                state_d = EOP_J;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
              end
            end
            EOP_J: begin
              state_d  = IDLE;
              active_d = 1'b0;
              line_j_d = 1'b1;
              ones_d   = '0;
              dp_d     = 1'b1;
              dm_d     = 1'b0;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end

    if (shift_bit) begin
      bit_idx_d = bit_idx_q + 4'd1;
      shreg_d   = {1'b0, shreg_q[7:1]};
      emit      = 1'b1;
      ebit      = shreg_q[1];
    end
    if (load_byte) begin
      state_d     = DATA;
      bit_idx_d   = '0;
      shreg_d     = TX_packet_data;
      remain_d    = remain_q - 7'd1;
      get_tx_data = 1'b1;
      emit        = 1'b1;
      ebit        = TX_packet_data[0];
      crc_upd     = 1'b1;
    end
    if (to_crc) begin
      state_d   = CRC;
      bit_idx_d = '0;
      emit      = 1'b1;
      ebit      = ~crc_q[0];
    end
    if (crc_upd) crc_d = crc_step(crc_q, ebit);
    // NRZI: a zero toggles J/K, a one holds the line.
    if (emit) begin
      line_j_d = ebit ? line_j_q : ~line_j_q;
      dp_d     = line_j_d;
      dm_d     = ~line_j_d;
      ones_d   = ebit ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q            <= IDLE;
      clk_cnt_q          <= '0;
      bit_idx_q          <= '0;
      shreg_q            <= '0;
      crc_q              <= 16'hFFFF;
      ones_q             <= '0;
      line_j_q           <= 1'b1;
      pid_q              <= '0;
      remain_q           <= '0;
      dp_out             <= 1'b1;
      dm_out             <= 1'b0;
      tx_transfer_active <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      state_q            <= state_d;
      clk_cnt_q          <= clk_cnt_d;
      bit_idx_q          <= bit_idx_d;
      shreg_q            <= shreg_d;
      crc_q              <= crc_d;
      ones_q             <= ones_d;
      line_j_q           <= line_j_d;
      pid_q              <= pid_d;
      remain_q           <= remain_d;
      dp_out             <= dp_d;
      dm_out             <= dm_d;
      tx_transfer_active <= active_d;
      tx_error           <= error_d;
    end
  end
endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: a wire monitor records one line symbol per bit period, a receiver decodes it.
module tb_usb_tx;
  localparam int CPB = 8;

  logic       tb_clk = 1'b0;
  logic       n_rst, tx_start;
  logic [2:0] tx_packet;
  logic [6:0] buff_occ;
  logic [7:0] TX_packet_data;
  logic       get_tx_data, dp_out, dm_out, tx_transfer_active, tx_error;

  always #5 tb_clk = ~tb_clk;

  usb_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(tb_clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet),
    .buff_occ(buff_occ), .TX_packet_data(TX_packet_data), .get_tx_data(get_tx_data),
    .dp_out(dp_out), .dm_out(dm_out), .tx_transfer_active(tx_transfer_active),
    .tx_error(tx_error)
  );

  // Buffer model: head byte presented combinationally, advanced on each pop.
  logic [7:0] buf_mem [8];
  int head = 0;
  assign TX_packet_data = buf_mem[head[2:0]];
  always @(posedge tb_clk) if (get_tx_data) head <= head + 1;

  logic [1:0] sym_q[$];
  int pop_cnt = 0, err_clks = 0, act_clks = 0, idle_bad = 0, phase = 0;
  always @(negedge tb_clk) begin
    if (get_tx_data) pop_cnt++;
    if (tx_error) err_clks++;
    if (tx_transfer_active) begin
      if (phase == 0) sym_q.push_back({dp_out, dm_out});
      phase = (phase == CPB - 1) ? 0 : phase + 1;
      act_clks++;
    end else begin
      phase = 0;
      if (n_rst && !(dp_out && !dm_out)) idle_bad++;
    end
  end

  int errors = 0, checks = 0;
  int b_sym, b_pop, b_err, b_act, b_bad;
  logic [7:0] dec_q[$];
  logic [7:0] exp_q[$];
  int stuff_q[$];
  int nper;
  logic eop_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge tb_clk); #1; end
  endtask

  task automatic snap();
    b_sym = sym_q.size(); b_pop = pop_cnt; b_err = err_clks; b_act = act_clks; b_bad = idle_bad;
  endtask

  task automatic do_start(input logic [2:0] code, input logic [6:0] occ);
    tx_start = 1'b1; tx_packet = code; buff_occ = occ;
    tick(1);
    tx_start = 1'b0; tx_packet = 3'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_transfer_active && n < 2000) begin tick(1); n++; end
    check({tag, "_done"}, {31'd0, tx_transfer_active}, 32'd0);
    tick(3);
  endtask

  // NRZI decode and destuff the periods recorded since base.
  task automatic decode(input int base);
    logic [1:0] prev, s;
    logic       b;
    logic [7:0] cur;
    int ones, bitpos;
    dec_q.delete(); stuff_q.delete();
    nper = sym_q.size() - base;
    eop_ok = 1'b0;
    if (nper >= 3)
      eop_ok = (sym_q[base+nper-3] == 2'b00) && (sym_q[base+nper-2] == 2'b00) &&
               (sym_q[base+nper-1] == 2'b10);
    prev = 2'b10; ones = 0; bitpos = 0; cur = 8'h00;
    for (int i = 0; i < nper - 3; i++) begin
      s = sym_q[base+i];
      b = (s == prev);
      prev = s;
      if (ones == 6) begin
        stuff_q.push_back(b ? -1 : i);
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        cur[bitpos] = b;
        bitpos++;
        if (bitpos == 8) begin dec_q.push_back(cur); bitpos = 0; end
      end
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, dec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, dec_q[i]}, {24'd0, exp_q[i]});
  endtask

  function automatic logic [15:0] crc_ref2(input logic [7:0] d0, input logic [7:0] d1);
    logic [15:0] c = 16'hFFFF;
    logic [15:0] d = {d1, d0};
    for (int i = 0; i < 16; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return ~c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    logic [15:0] crc_exp;
    n_rst = 1'b0; tx_start = 1'b0; tx_packet = 3'd0; buff_occ = 7'd0;
    for (int i = 0; i < 8; i++) buf_mem[i] = 8'h00;
    tick(3);
    check("rst_dp", {31'd0, dp_out}, 32'd1);
    check("rst_dm", {31'd0, dm_out}, 32'd0);
    check("rst_get", {31'd0, get_tx_data}, 32'd0);
    check("rst_active", {31'd0, tx_transfer_active}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    n_rst = 1'b1;
    tick(2);

    // ACK handshake
    snap();
    do_start(3'd3, 7'd0);
    check("ack_active_rise", {31'd0, tx_transfer_active}, 32'd1);
    check("ack_first_k", {30'd0, dp_out, dm_out}, 32'b01);
    wait_idle("ack");
    decode(b_sym);
    check("ack_periods", nper, 19);
    check("ack_active_clks", act_clks - b_act, 152);
    check("ack_pops", pop_cnt - b_pop, 0);
    check("ack_eop", {31'd0, eop_ok}, 32'd1);
    check("ack_stuffs", stuff_q.size(), 0);
    exp_q = '{8'h80, 8'hD2};
    check_bytes("ack");

    // Zero-length DATA0
    snap();
    do_start(3'd1, 7'd0);
    wait_idle("zlp");
    decode(b_sym);
    check("zlp_periods", nper, 35);
    check("zlp_pops", pop_cnt - b_pop, 0);
    check("zlp_eop", {31'd0, eop_ok}, 32'd1);
    exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
    check_bytes("zlp");

    // DATA1 carrying 8'hFF: stuffing in payload and in CRC
    buf_mem[head[2:0]] = 8'hFF;
    snap();
    do_start(3'd2, 7'd1);
    wait_idle("ff");
    decode(b_sym);
    check("ff_pops", pop_cnt - b_pop, 1);
    check("ff_periods", nper, 45);
    check("ff_nstuff", stuff_q.size(), 2);
    if (stuff_q.size() == 2) begin
      check("ff_stuff0_pos", stuff_q[0], 22);
      check("ff_stuff1_pos", stuff_q[1], 39);
    end
    check("ff_eop", {31'd0, eop_ok}, 32'd1);
    exp_q = '{8'h80, 8'h4B, 8'hFF, 8'h00, 8'hFF};
    check_bytes("ff");

    // Invalid code 6
    snap();
    do_start(3'd6, 7'd0);
    check("inv_err_pulse", {31'd0, tx_error}, 32'd1);
    check("inv_active", {31'd0, tx_transfer_active}, 32'd0);
    tick(12);
    check("inv_err_clks", err_clks - b_err, 1);
    check("inv_act_clks", act_clks - b_act, 0);
    check("inv_line_j", idle_bad - b_bad, 0);

    // Code 0 is ignored
    snap();
    do_start(3'd0, 7'd3);
    tick(12);
    check("none_act_clks", act_clks - b_act, 0);
    check("none_err_clks", err_clks - b_err, 0);

    // Reset after the second pop of a 4-byte DATA0
    for (int i = 0; i < 4; i++) buf_mem[(head + i) % 8] = 8'h11 * (i + 1);
    snap();
    do_start(3'd1, 7'd4);
    n = 0; seen = 0;
    while (seen < 2 && n < 600) begin
      tick(1); n++;
      if (get_tx_data) seen++;
    end
    n_rst = 1'b0;
    check("rstmid_second_pop", seen, 2);
    tick(1);
    check("rstmid_dp", {31'd0, dp_out}, 32'd1);
    check("rstmid_dm", {31'd0, dm_out}, 32'd0);
    check("rstmid_active", {31'd0, tx_transfer_active}, 32'd0);
    check("rstmid_get", {31'd0, get_tx_data}, 32'd0);
    check("rstmid_error", {31'd0, tx_error}, 32'd0);
    n_rst = 1'b1;
    tick(20);
    check("rstmid_pops", pop_cnt - b_pop, 2);
    check("rstmid_line_j", idle_bad - b_bad, 0);

    // ACK request while a DATA0 packet is on the wire
    buf_mem[head[2:0]] = 8'hA5;
    buf_mem[(head + 1) % 8] = 8'h3C;
    snap();
    do_start(3'd1, 7'd2);
    tick(150);
    tx_start = 1'b1; tx_packet = 3'd3; buff_occ = 7'd0;
    tick(1);
    tx_start = 1'b0; tx_packet = 3'd0;
    wait_idle("busy");
    decode(b_sym);
    crc_exp = crc_ref2(8'hA5, 8'h3C);
    check("busy_err_clks", err_clks - b_err, 0);
    check("busy_pops", pop_cnt - b_pop, 2);
    check("busy_eop", {31'd0, eop_ok}, 32'd1);
    exp_q = '{8'h80, 8'hC3, 8'hA5, 8'h3C, crc_exp[7:0], crc_exp[15:8]};
    check_bytes("busy");
    tick(5);
    check("busy_no_followup", act_clks - b_act, nper * CPB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
